// File: rtl/ram8_fifo_pkg.sv
// Shared encodings for the RAM-backed FIFO sequencer and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram8_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH_DEF  = 8;

  // Which side owns the single RAM port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PUSH = 2'd1,
    GRANT_POP  = 2'd2
  } grant_e;

  // RUN issues grants; CLR is the one-cycle RAM wipe after a flush.
  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CLR = 1'b1
  } state_e;

endpackage

// File: rtl/ram8_fifo_arb.sv
// Single-port grant arbiter: picks PUSH, POP or nothing for the shared RAM port.
// Latency: purely combinational from current state and requests.
// Backpressure: ready flags drop when full/empty, during flush/CLR, or when the other side wins the alternation.
module ram8_fifo_arb
  import ram8_fifo_pkg::*;
(
  input  logic   push_valid,
  input  logic   pop_req,
  input  logic   full,
  input  logic   empty,
  input  logic   flush,
  input  grant_e last_grant,
  input  state_e state,
  output grant_e grant,
  output logic   push_ready,
  output logic   pop_ready
);

  logic blocked;

  // A flush request or the wipe cycle takes the port away from both clients.
  assign blocked = flush || (state == ST_CLR);

  // Readiness is "would be granted if this side asked": contention only matters
  // when the other side is actually requesting and both operations are legal.
  always_comb begin
    push_ready = !blocked && !full &&
                 (!pop_req || empty || (last_grant == GRANT_POP));
    pop_ready  = !blocked && !empty &&
                 (!push_valid || full || (last_grant == GRANT_PUSH));
  end

  // The two ready terms are mutually exclusive under contention, so a simple
  // priority select cannot hide a conflict.
  always_comb begin
    grant = GRANT_NONE;
    if (push_valid && push_ready) begin
      grant = GRANT_PUSH;
    end else if (pop_req && pop_ready) begin
      grant = GRANT_POP;
    end
  end

endmodule

// File: rtl/ram8x8.sv
// Behavioural stand-in for the 8x8 JK-flip-flop RAM: combinational read, write on rising edge.
// Latency: read is combinational from addr; write lands on the rising edge with rw=1.
// Backpressure: none; clear asynchronously zeroes every word.
module ram8x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Storage array: async wipe, otherwise capture din at addr when writing.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
    end else if (rw) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/ram8_fifo_ctrl.sv
// FIFO sequencer in front of a single-port 8x8 RAM: owns pointers, count and the RAM pins.
// Latency: push lands on the grant edge; pop_data/pop_valid appear one cycle after the pop grant.
// Backpressure: push_ready/pop_ready from the arbiter; fair alternation when both sides contend.
module ram8_fifo_ctrl
  import ram8_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_req,
  output logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              mem_clear
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  grant_e            grant;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;

  ram8_fifo_arb u_arb (
    .push_valid (push_valid),
    .pop_req    (pop_req),
    .full       (full),
    .empty      (empty),
    .flush      (flush),
    .last_grant (last_grant_q),
    .state      (state_q),
    .grant      (grant),
    .push_ready (push_ready),
    .pop_ready  (pop_ready)
  );

  // Wipe FSM: a sampled flush spends exactly one cycle in CLR holding the RAM clear.
  always_comb begin
    state_d = ST_RUN;
    if (flush) begin
      state_d = ST_CLR;
    end
  end

  // Pointer, occupancy and dequeue-register next state; flush overrides any grant.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    pop_data_d   = pop_data_q;
    pop_valid_d  = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (grant)
        GRANT_PUSH: begin
          // DEPTH is a power of two, so natural overflow of the pointer is the wrap.
          wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
          count_d      = count_q + (ADDR_W+1)'(1);
          last_grant_d = GRANT_PUSH;
        end
        GRANT_POP: begin
          rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
          count_d      = count_q - (ADDR_W+1)'(1);
          last_grant_d = GRANT_POP;
          pop_data_d   = mem_dout;
          pop_valid_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset starts with POP as last grant so a contended first cycle favours PUSH.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= ST_RUN;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= GRANT_POP;
      pop_data_q   <= '0;
      pop_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      pop_data_q   <= pop_data_d;
      pop_valid_q  <= pop_valid_d;
    end
  end

  // RAM pin mux: idle parks the address on the read pointer with writes off.
  always_comb begin
    mem_addr = rd_ptr_q;
    mem_rw   = 1'b0;
    mem_din  = '0;
    if (grant == GRANT_PUSH) begin
      mem_addr = wr_ptr_q;
      mem_rw   = 1'b1;
      mem_din  = push_data;
    end
  end

  assign mem_clear = clear || (state_q == ST_CLR);
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Bench for ram8_fifo_ctrl driving the 8x8 RAM model; pops are checked by a queue-based monitor.
module tb_ram8_fifo_ctrl;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = '0;
  logic       push_ready;
  logic       pop_req = 1'b0;
  logic       pop_ready;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       flush = 1'b0;
  logic       full, empty;
  logic [3:0] count;
  logic [2:0] mem_addr;
  logic       mem_rw;
  logic [7:0] mem_din, mem_dout;
  logic       mem_clear;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  int         exp_cyc[$];

  logic       ap, ao, rw;
  logic [2:0] addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ram8_fifo_ctrl dut (
    .clk(clk), .clear(clear),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_ready(pop_ready), .pop_data(pop_data), .pop_valid(pop_valid),
    .flush(flush), .full(full), .empty(empty), .count(count),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_clear(mem_clear)
  );

  ram8x8 u_ram (
    .clk(clk), .clear(mem_clear), .addr(mem_addr), .rw(mem_rw), .din(mem_din), .dout(mem_dout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, record grant, advance past the posedge, go idle.
  task automatic step(input logic pv, input logic [7:0] pd, input logic pr, input logic fl,
                      output logic acc_push, output logic acc_pop,
                      output logic [2:0] a, output logic w);
    @(negedge clk);
    push_valid = pv; push_data = pd; pop_req = pr; flush = fl;
    #1;
    acc_push = pv && push_ready;
    acc_pop  = pr && pop_ready;
    a = mem_addr;
    w = mem_rw;
    if (fl) begin
      model.delete();
    end else if (acc_push) begin
      model.push_back(pd);
    end else if (acc_pop) begin
      if (model.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_grant_when_model_empty: got grant expected none");
      end else begin
        exp_q.push_back(model.pop_front());
        exp_cyc.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0; pop_req = 1'b0; flush = 1'b0; push_data = '0;
  endtask

  // Monitor: every pop_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!clear && pop_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_pop_valid: got data 0x%0h expected no pulse", pop_data);
      end else begin
        chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
        chk("pop_latency", 32'(cyc), 32'(exp_cyc.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [3];
    logic [7:0] b  [4];
    logic       exp_rw [4];
    int k;
    t1 = '{8'h25, 8'h07, 8'h76};
    b  = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    exp_rw = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_pop_ready", 32'(pop_ready), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    chk("rst_mem_clear", 32'(mem_clear), 1);
    @(negedge clk); clear = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_clear", 32'(mem_clear), 0);

    // 1: three pushes then three pops
    for (int i = 0; i < 3; i++) begin
      step(1'b1, t1[i], 1'b0, 1'b0, ap, ao, addr, rw);
      chk("t1_push_acc", 32'(ap), 1);
      chk("t1_push_addr", 32'(addr), 32'(i));
      chk("t1_push_rw", 32'(rw), 1);
    end
    chk("t1_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, ap, ao, addr, rw);
      chk("t1_pop_acc", 32'(ao), 1);
      chk("t1_pop_rw", 32'(rw), 0);
    end
    chk("t1_empty", 32'(empty), 1);

    // 2: fill to full with wrap, overflow attempt, drain
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i + 1), 1'b0, 1'b0, ap, ao, addr, rw);
      chk("t2_push_addr", 32'(addr), 32'((3 + i) % 8));
    end
    chk("t2_full", 32'(full), 1);
    chk("t2_push_ready", 32'(push_ready), 0);
    step(1'b1, 8'h09, 1'b0, 1'b0, ap, ao, addr, rw);
    chk("t2_ninth_refused", 32'(ap), 0);
    chk("t2_ninth_rw", 32'(rw), 0);
    chk("t2_count_held", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, ap, ao, addr, rw);
      chk("t2_pop_addr", 32'(addr), 32'((3 + i) % 8));
    end
    chk("t2_empty", 32'(empty), 1);

    // 3: pop on empty
    step(1'b0, 8'h00, 1'b1, 1'b0, ap, ao, addr, rw);
    chk("t3_pop_ready", 32'(ao), 0);
    chk("t3_rw", 32'(rw), 0);
    @(negedge clk);
    chk("t3_no_pulse", 32'(pop_valid), 0);

    // 4: contention alternates starting with POP (last grant was PUSH)
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0, ap, ao, addr, rw);
    chk("t4_count_pre", 32'(count), 4);
    k = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[k], 1'b1, 1'b0, ap, ao, addr, rw);
      chk("t4_grant_rw", 32'(rw), 32'(exp_rw[i]));
      chk("t4_one_grant", 32'(ap ^ ao), 1);
      if (ap) k++;
    end
    chk("t4_count_post", 32'(count), 4);

    // 5: flush beats a simultaneous push
    step(1'b1, 8'hC5, 1'b0, 1'b0, ap, ao, addr, rw);
    chk("t5_count5", 32'(count), 5);
    step(1'b1, 8'hEE, 1'b0, 1'b1, ap, ao, addr, rw);
    chk("t5_flush_no_push", 32'(ap), 0);
    chk("t5_flush_rw", 32'(rw), 0);
    chk("t5_mem_clear", 32'(mem_clear), 1);
    chk("t5_count0", 32'(count), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, ap, ao, addr, rw);
    chk("t5_pop_refused", 32'(ao), 0);
    chk("t5_mem_clear_done", 32'(mem_clear), 0);

    // 6: async clear in the middle of a push cycle
    step(1'b1, 8'h55, 1'b0, 1'b0, ap, ao, addr, rw);
    step(1'b1, 8'h66, 1'b0, 1'b0, ap, ao, addr, rw);
    step(1'b0, 8'h00, 1'b1, 1'b0, ap, ao, addr, rw);
    @(negedge clk);
    push_valid = 1'b1; push_data = 8'h11;
    #2 clear = 1'b1;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_pop_valid", 32'(pop_valid), 0);
    chk("t6_mem_clear", 32'(mem_clear), 1);
    model.delete();
    @(negedge clk);
    clear = 1'b0; push_valid = 1'b0; push_data = '0;
    step(1'b1, 8'hAA, 1'b0, 1'b0, ap, ao, addr, rw);
    chk("t6_push_addr", 32'(addr), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, ap, ao, addr, rw);
    chk("t6_pop_acc", 32'(ao), 1);

    repeat (3) @(negedge clk);
    chk("drain_outstanding", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
